prf_read_req_arbiter: RTL
=========================

Name: prf_read_req_arbiter

Overview:
- Arbitrates the PRF_RR_COUNT physical-register read requesters onto the PRF_BANK_COUNT banked PRF.
- Each bank serves one read per cycle.
- Sits between the IQ/issue read stage and the PRF array. It accepts requests with a valid/ready handshake and issues one registered read command per bank per cycle.
- Fairness: a round-robin pointer per bank, so every requester is served within a bounded time.

Parameters:
- PRF_RR_COUNT, 11, number of read requesters.
- PR_COUNT, 128, number of physical registers; LOG_PR_COUNT = $clog2(PR_COUNT) = 7.
- PRF_BANK_COUNT, 4, number of PRF banks; LOG_PRF_BANK_COUNT = 2.
- LOG_RR = $clog2(PRF_RR_COUNT) = 4, width of a requester index (derived).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- req_valid_by_rr  input  PRF_RR_COUNT  requester i has a pending read.
- req_PR_by_rr  input  PRF_RR_COUNT x LOG_PR_COUNT  PR index per requester; bank = PR[1:0], row = PR[6:2].
- req_ready_by_rr  output  PRF_RR_COUNT  combinational grant this cycle.
- bank_read_valid_by_bank  output  PRF_BANK_COUNT  registered read command valid.
- bank_read_row_by_bank  output  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  row to read.
- bank_read_rr_by_bank  output  PRF_BANK_COUNT x LOG_RR  requester index owning the read.
- bank_conflict_by_bank  output  PRF_BANK_COUNT  combinational; more than one requester targeted this bank this cycle.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous assert, active-low, on nRST.
- Reset values: all bank_read_* registers 0; all rr_ptr_by_bank 0.
- Handshake:
  - A requester holds req_valid and req_PR stable until it sees req_ready high in the same cycle.
  - The transfer completes on the rising edge where valid && ready.
  - req_ready is never high without req_valid.
- Per-bank arbitration (combinational, every bank independently):
  - Candidates: requesters with req_valid=1 and req_PR[1:0]==bank.
  - Winner: the first candidate at index >= rr_ptr_by_bank[bank], scanning upward and wrapping from PRF_RR_COUNT-1 to 0.
  - At most one grant per bank per cycle.
  - A requester maps to exactly one bank, so it is granted by at most one bank.
- Pointer update:
  - On a grant to index i: rr_ptr <= (i==PRF_RR_COUNT-1) ? 0 : i+1.
  - With no grant the pointer holds.
  - The pointer never holds a value >= PRF_RR_COUNT.
- Output register (latency exactly 1 cycle from grant):
  - bank_read_valid[b] <= grant exists for b.
  - bank_read_row[b] <= winner PR[6:2]; bank_read_rr[b] <= winner index.
  - With no grant, valid <= 0 and row/rr hold their previous values.
- Fairness bound: a continuously valid requester is granted within PRF_RR_COUNT cycles of first asserting valid.
- Simultaneous events:
  - All 11 requesters on one bank: one grant per cycle in rotating order. The other banks idle with valid=0.
  - Requesters spread across banks: up to 4 grants per cycle.
- Same PR from two requesters: treated as independent requests; no read merging.
- Reset mid-operation: outstanding registered reads are dropped (valid -> 0) and pointers return to 0. Requesters must re-present their requests after reset.
- bank_conflict[b] = popcount(candidates of b) > 1, combinational.

Optional Feature:
- Macro: PRF_READ_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_conflict_cycles, 32 bits.
  - Adds output perf_grant_count, 32 bits.
  - Both reset to 0 and wrap modulo 2^32.
  - perf_conflict_cycles increments by 1 in any cycle where at least one bank_conflict bit is set.
  - perf_grant_count adds the number of grants issued that cycle (0..4).
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: hold nRST=0 with all 11 requests valid -> all bank_read_valid=0 and req_ready=0 (outputs registered, pointers 0). Release -> first cycle grants the lowest index per bank.
- Single request: rr 3 valid, PR=0x2D (bank 1, row 11) -> req_ready[3]=1 same cycle; next cycle bank_read_valid[1]=1, row=11, rr=3.
- Same-bank contention: rr 0, 5, 10 each target bank 2 (PR 0x02, 0x06, 0x0A), held until granted -> grants rr0, rr5, rr10 on consecutive cycles, each read registered one cycle after its grant; ptr[2] wraps to 0 after rr10.
- Parallel banks: rr 1, 2, 3, 4 target banks 0, 1, 2, 3 -> all four ready in one cycle; next cycle all four bank_read_valid=1; bank_conflict=0000.
- Wrap fairness: ptr[0]=9 (set up by granting rr8), then rr 2 and rr 9 both valid on bank 0 -> rr9 granted first, then rr2; ptr ends at 3.
- Perf (with PRF_READ_ARB_PERF_CNT_EN): 3 cycles with one 2-way conflict on bank 0 while banks 1 and 3 each have a single request -> perf_conflict_cycles=3, perf_grant_count=9.

Source files
------------

// File: rtl/prf_read_req_arbiter_if.sv
// Read-request bus between the issue read stage and the banked PRF arbiter.
// The requester side drives the master modport and the arbiter takes the slave modport.
interface prf_read_req_arbiter_if #(
  parameter int PRF_RR_COUNT   = 11,
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4
);
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_RR             = $clog2(PRF_RR_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  logic [PRF_RR_COUNT-1:0]                    req_valid_by_rr;
  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]  req_PR_by_rr;
  logic [PRF_RR_COUNT-1:0]                    req_ready_by_rr;
  logic [PRF_BANK_COUNT-1:0]                  bank_read_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]       bank_read_row_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_RR-1:0]      bank_read_rr_by_bank;
  logic [PRF_BANK_COUNT-1:0]                  bank_conflict_by_bank;

  modport master (
    output req_valid_by_rr,
    output req_PR_by_rr,
    input  req_ready_by_rr,
    input  bank_read_valid_by_bank,
    input  bank_read_row_by_bank,
    input  bank_read_rr_by_bank,
    input  bank_conflict_by_bank
  );

  modport slave (
    input  req_valid_by_rr,
    input  req_PR_by_rr,
    output req_ready_by_rr,
    output bank_read_valid_by_bank,
    output bank_read_row_by_bank,
    output bank_read_rr_by_bank,
    output bank_conflict_by_bank
  );
endinterface

// File: rtl/prf_read_req_arbiter.sv
// Per-bank round-robin arbiter of PRF read requesters with registered read commands.
// Define PRF_READ_ARB_PERF_CNT_EN to add the conflict-cycle and grant performance counters.
module prf_read_req_arbiter #(
  parameter int PRF_RR_COUNT   = 11,
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4
) (
  input logic                   CLK,
  input logic                   nRST,
  prf_read_req_arbiter_if.slave rd_if
`ifdef PRF_READ_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_conflict_cycles,
  output logic [31:0]           perf_grant_count
`endif
);

  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_RR             = $clog2(PRF_RR_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam logic [LOG_RR-1:0] LAST_RR = LOG_RR'(PRF_RR_COUNT - 1);

  logic [PRF_BANK_COUNT-1:0][LOG_RR-1:0]       rr_ptr_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] cand_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] upper_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] sel_by_bank;
  logic [PRF_BANK_COUNT-1:0]                   grant_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_RR-1:0]       win_rr_by_bank;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]        win_row_by_bank;
  logic [PRF_BANK_COUNT-1:0]                   conflict_by_bank;
  logic [PRF_RR_COUNT-1:0]                     req_ready;

  logic [PRF_BANK_COUNT-1:0]                   read_valid_q;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]        read_row_q;
  logic [PRF_BANK_COUNT-1:0][LOG_RR-1:0]       read_rr_q;

  // Candidates per bank, plus the subset at or above the bank's pointer.
  always_comb begin
    cand_by_bank  = '0;
    upper_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        cand_by_bank[b][i] = rd_if.req_valid_by_rr[i] &&
          (rd_if.req_PR_by_rr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
        upper_by_bank[b][i] = cand_by_bank[b][i] && (LOG_RR'(i) >= rr_ptr_by_bank[b]);
      end
    end
  end

  // Wrapping scan: take the lowest candidate above the pointer, else the lowest overall.
  // Grants are suppressed while reset is asserted so no handshake completes in reset.
  always_comb begin
    sel_by_bank     = '0;
    grant_by_bank   = '0;
    win_rr_by_bank  = '0;
    win_row_by_bank = '0;
    req_ready       = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      sel_by_bank[b]   = (|upper_by_bank[b]) ? upper_by_bank[b] : cand_by_bank[b];
      grant_by_bank[b] = (|cand_by_bank[b]) && nRST;
      for (int i = PRF_RR_COUNT - 1; i >= 0; i--) begin
        if (sel_by_bank[b][i]) begin
          win_rr_by_bank[b]  = LOG_RR'(i);
          win_row_by_bank[b] = rd_if.req_PR_by_rr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
      end
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        if (grant_by_bank[b] && (win_rr_by_bank[b] == LOG_RR'(i))) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    conflict_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      conflict_by_bank[b] = ($countones(cand_by_bank[b]) > 1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_by_bank <= '0;
      read_valid_q   <= '0;
      read_row_q     <= '0;
      read_rr_q      <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        read_valid_q[b] <= grant_by_bank[b];
        if (grant_by_bank[b]) begin
          read_row_q[b]     <= win_row_by_bank[b];
          read_rr_q[b]      <= win_rr_by_bank[b];
          rr_ptr_by_bank[b] <= (win_rr_by_bank[b] == LAST_RR) ? '0
                                                               : win_rr_by_bank[b] + LOG_RR'(1);
        end
      end
    end
  end

  assign rd_if.req_ready_by_rr         = req_ready;
  assign rd_if.bank_conflict_by_bank   = conflict_by_bank;
  assign rd_if.bank_read_valid_by_bank = read_valid_q;
  assign rd_if.bank_read_row_by_bank   = read_row_q;
  assign rd_if.bank_read_rr_by_bank    = read_rr_q;

`ifdef PRF_READ_ARB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_conflict_cycles <= '0;
      perf_grant_count     <= '0;
    end else begin
      perf_conflict_cycles <= perf_conflict_cycles + 32'(|conflict_by_bank);
      perf_grant_count     <= perf_grant_count + 32'($countones(grant_by_bank));
    end
  end
`endif

endmodule
